// File: rtl/eggtimer_ctrl.sv
// -----------------------------------------------------------------------------
// eggtimer_ctrl
//
// Control stage that sits directly upstream of the egg timer's digit_counter
// chain. It turns two pre-debounced button pulses into run/pause/done
// sequencing, produces the 1 Hz count-enable tick for the least-significant
// digit, produces the preset reload pulse, and drives the alarm outputs once
// the digit chain reports all digits at zero.
//
// Parameters
//   TICK_DIV     clk cycles per tick_en pulse (legal >= 2)
//
// Ports
//   clk          in   1  system clock, rising edge
//   reset_n      in   1  asynchronous, active-low reset
//   start_btn    in   1  one-cycle pulse: start / pause / resume / acknowledge
//   clear_btn    in   1  one-cycle pulse: abort and reload preset (wins over start)
//   all_zero     in   1  high when every digit counter reads 0
//   load         out  1  one-cycle reload pulse to the digit counters
//   tick_en      out  1  one-cycle count enable to the least-significant digit
//   running      out  1  high while in RUN
//   alarm        out  1  high while in DONE
//   alarm_blink  out  1  toggles once per tick period while in DONE, else 0
//   state        out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
//
// Every output is a flop. The next-state/next-output logic is one
// combinational process and the registers are a second, clocked process.
// -----------------------------------------------------------------------------
module eggtimer_ctrl #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_btn,
  input  logic       clear_btn,
  input  logic       all_zero,
  output logic       load,
  output logic       tick_en,
  output logic       running,
  output logic       alarm,
  output logic       alarm_blink,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LP_WRAP = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] LP_ONE  = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Registered state and outputs
  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          r_load;
  logic          r_tick;
  logic          r_running;
  logic          r_alarm;
  logic          r_blink;

  // Next-value nets
  state_t        w_state_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic [PW-1:0] w_presc_inc;
  logic          w_wrap;
  logic          w_load_nxt;
  logic          w_tick_nxt;
  logic          w_blink_cand;
  logic          w_blink_nxt;

  // Prescaler step: wraps to zero after TICK_DIV-1, so it never exceeds it.
  function automatic logic [PW-1:0] f_presc_step(input logic [PW-1:0] cur);
    if (cur == LP_WRAP) begin
      return '0;
    end
    return cur + LP_ONE;
  endfunction

  assign w_wrap      = (r_presc == LP_WRAP);
  assign w_presc_inc = f_presc_step(r_presc);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_presc_nxt  = r_presc;
    w_load_nxt   = 1'b0;
    w_tick_nxt   = 1'b0;
    w_blink_cand = r_blink;

    if (clear_btn) begin
      // Abort from anywhere: reload preset, drop every alarm indication.
      w_state_nxt  = S_IDLE;
      w_presc_nxt  = '0;
      w_load_nxt   = 1'b1;
      w_blink_cand = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // Starting with nothing on the display would expire immediately.
          if (start_btn && !all_zero) begin
            w_state_nxt = S_RUN;
            w_presc_nxt = '0;
          end
        end

        S_RUN: begin
          if (start_btn) begin
            // Pause freezes the prescaler where it is.
            w_state_nxt = S_PAUSE;
          end else if (all_zero) begin
            // Expiry is checked ahead of the wrap so no stray tick reaches
            // a chain that is already at zero.
            w_state_nxt  = S_DONE;
            w_presc_nxt  = '0;
            w_blink_cand = 1'b1;
          end else begin
            w_presc_nxt = w_presc_inc;
            w_tick_nxt  = w_wrap;
          end
        end

        S_PAUSE: begin
          // Resume counts this edge as a running cycle so the partially
          // elapsed second is honoured, not restarted.
          if (start_btn) begin
            w_state_nxt = S_RUN;
            w_presc_nxt = w_presc_inc;
            w_tick_nxt  = w_wrap;
          end
        end

        S_DONE: begin
          if (start_btn) begin
            // Acknowledge: silence the alarm and reload the preset.
            w_state_nxt  = S_IDLE;
            w_presc_nxt  = '0;
            w_load_nxt   = 1'b1;
            w_blink_cand = 1'b0;
          end else begin
            w_presc_nxt = w_presc_inc;
            if (w_wrap) begin
              w_blink_cand = ~r_blink;
            end
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_presc_nxt = '0;
        end
      endcase
    end

    // Blink only ever shows while the alarm is sounding.
    w_blink_nxt = (w_state_nxt == S_DONE) ? w_blink_cand : 1'b0;
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_load    <= 1'b0;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
      r_blink   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_load    <= w_load_nxt;
      r_tick    <= w_tick_nxt;
      r_running <= (w_state_nxt == S_RUN);
      r_alarm   <= (w_state_nxt == S_DONE);
      r_blink   <= w_blink_nxt;
    end
  end

  assign load        = r_load;
  assign tick_en     = r_tick;
  assign running     = r_running;
  assign alarm       = r_alarm;
  assign alarm_blink = r_blink;
  assign state       = r_state;

endmodule

// File: tb/tb_eggtimer_ctrl.sv
module tb_eggtimer_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start_btn, clear_btn, all_zero;
  logic       load, tick_en, running, alarm, alarm_blink;
  logic [1:0] state;

  // Second instance with a longer divider for the period measurement.
  logic       b_start, b_clear, b_all_zero;
  logic       b_load, b_tick, b_running, b_alarm, b_blink;
  logic [1:0] b_state;

  int checks;
  int failures;

  eggtimer_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .start_btn(start_btn), .clear_btn(clear_btn),
    .all_zero(all_zero), .load(load), .tick_en(tick_en), .running(running),
    .alarm(alarm), .alarm_blink(alarm_blink), .state(state)
  );

  eggtimer_ctrl #(.TICK_DIV(1000)) dut_long (
    .clk(clk), .reset_n(reset_n), .start_btn(b_start), .clear_btn(b_clear),
    .all_zero(b_all_zero), .load(b_load), .tick_en(b_tick), .running(b_running),
    .alarm(b_alarm), .alarm_blink(b_blink), .state(b_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
  endtask

  task automatic press_clear();
    clear_btn = 1'b1;
    step();
    clear_btn = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start_btn = 1'b0; clear_btn = 1'b0; all_zero = 1'b0;
    b_start = 1'b0; b_clear = 1'b0; b_all_zero = 1'b0;
    #3;
    checks++;
    if ({state, load, tick_en, running, alarm, alarm_blink} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000000", {state, load, tick_en, running, alarm, alarm_blink});
    end
    step(); step();
    reset_n = 1'b1;
    step();
    checks++;
    if (state !== 2'd0 || tick_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_release state=%0d tick=%0d exp state=0 tick=0", state, tick_en);
    end
  endtask

  // Start from IDLE, ticks at +4, +8, +12 after the entry edge.
  task automatic test_run_ticks();
    press_start();
    checks++;
    if (state !== 2'd1 || running !== 1'b1 || tick_en !== 1'b0) begin
      failures++;
      $display("FAIL run_entry state=%0d running=%0d tick=%0d exp 1 1 0", state, running, tick_en);
    end
    for (int k = 1; k <= 13; k++) begin
      step();
      checks++;
      if (tick_en !== ((k % 4) == 0) || load !== 1'b0) begin
        failures++;
        $display("FAIL run_tick k=%0d tick=%0d load=%0d exp tick=%0d load=0", k, tick_en, load, ((k % 4) == 0));
      end
    end
  endtask

  task automatic test_pause();
    press_clear();
    press_start();          // entry edge E0
    step();                 // E1
    press_start();          // sampled at E2
    checks++;
    if (state !== 2'd2 || running !== 1'b0) begin
      failures++;
      $display("FAIL pause_entry state=%0d running=%0d exp 2 0", state, running);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (tick_en !== 1'b0 || state !== 2'd2) begin
        failures++;
        $display("FAIL pause_hold k=%0d tick=%0d state=%0d exp tick=0 state=2", k, tick_en, state);
      end
    end
    press_start();          // resume edge R
    checks++;
    if (state !== 2'd1 || tick_en !== 1'b0) begin
      failures++;
      $display("FAIL resume state=%0d tick=%0d exp 1 0", state, tick_en);
    end
    step();
    checks++;
    if (tick_en !== 1'b0) begin
      failures++;
      $display("FAIL resume_r1 tick=%0d exp 0", tick_en);
    end
    step();
    checks++;
    if (tick_en !== 1'b1) begin
      failures++;
      $display("FAIL resume_r2 tick=%0d exp 1", tick_en);
    end
    step();
    checks++;
    if (tick_en !== 1'b0) begin
      failures++;
      $display("FAIL resume_r3 tick=%0d exp 0", tick_en);
    end
  endtask

  // Expiry on the same edge the prescaler would wrap, then blink and ack.
  task automatic test_done();
    press_clear();
    press_start();          // E0
    step(); step(); step(); // E1..E3, prescaler now at 3
    all_zero = 1'b1;
    step();                 // E4: expiry must beat the wrap
    all_zero = 1'b0;
    checks++;
    if (state !== 2'd3 || alarm !== 1'b1 || alarm_blink !== 1'b1 || tick_en !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL done_entry state=%0d alarm=%0d blink=%0d tick=%0d running=%0d exp 3 1 1 0 0",
               state, alarm, alarm_blink, tick_en, running);
    end
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++;
      if (alarm_blink !== (((k / 4) % 2) == 0) || tick_en !== 1'b0 || alarm !== 1'b1) begin
        failures++;
        $display("FAIL done_blink k=%0d blink=%0d tick=%0d alarm=%0d exp blink=%0d tick=0 alarm=1",
                 k, alarm_blink, tick_en, alarm, (((k / 4) % 2) == 0));
      end
    end
    press_start();
    checks++;
    if (state !== 2'd0 || load !== 1'b1 || alarm !== 1'b0 || alarm_blink !== 1'b0) begin
      failures++;
      $display("FAIL done_ack state=%0d load=%0d alarm=%0d blink=%0d exp 0 1 0 0", state, load, alarm, alarm_blink);
    end
    step();
    checks++;
    if (load !== 1'b0) begin
      failures++;
      $display("FAIL done_ack_load_width load=%0d exp 0", load);
    end
  endtask

  task automatic test_clear_priority();
    press_start();
    step();
    start_btn = 1'b1;
    clear_btn = 1'b1;
    step();
    start_btn = 1'b0;
    clear_btn = 1'b0;
    checks++;
    if (state !== 2'd0 || load !== 1'b1 || tick_en !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL clear_prio state=%0d load=%0d tick=%0d running=%0d exp 0 1 0 0", state, load, tick_en, running);
    end
    step();
    checks++;
    if (load !== 1'b0) begin
      failures++;
      $display("FAIL clear_load_width load=%0d exp 0", load);
    end
    all_zero = 1'b1;
    press_start();
    all_zero = 1'b0;
    checks++;
    if (state !== 2'd0 || running !== 1'b0 || load !== 1'b0) begin
      failures++;
      $display("FAIL idle_zero_start state=%0d running=%0d load=%0d exp 0 0 0", state, running, load);
    end
  endtask

  // Asynchronous reset while tick_en is high, between edges.
  task automatic test_async_reset();
    press_clear();
    press_start();
    step(); step(); step(); step();   // tick_en high now
    checks++;
    if (tick_en !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_tick tick=%0d exp 1", tick_en);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || tick_en !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL async_reset state=%0d tick=%0d running=%0d exp 0 0 0", state, tick_en, running);
    end
    #2;
    reset_n = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (tick_en !== 1'b0 || state !== 2'd0) begin
        failures++;
        $display("FAIL post_reset_idle k=%0d tick=%0d state=%0d exp 0 0", k, tick_en, state);
      end
    end
  endtask

  // Longer divider: first tick 1000 cycles after entry, then 1000-cycle period.
  task automatic test_long_period();
    int cyc;
    int last;
    int found;
    b_clear = 1'b1;
    step();
    b_clear = 1'b0;
    b_start = 1'b1;
    step();                 // entry edge, cycle 0
    b_start = 1'b0;
    cyc  = 0;
    last = 0;
    for (int t = 0; t < 3; t++) begin
      found = 0;
      for (int k = 0; k < 1100 && found == 0; k++) begin
        step();
        cyc++;
        if (b_tick === 1'b1) found = 1;
      end
      checks++;
      if (found == 0) begin
        failures++;
        $display("FAIL long_tick_timeout t=%0d no tick within 1100 cycles", t);
      end else if (cyc - last !== 1000) begin
        failures++;
        $display("FAIL long_period t=%0d got=%0d exp=1000", t, cyc - last);
      end
      last = cyc;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_run_ticks();
    test_pause();
    test_done();
    test_clear_priority();
    test_async_reset();
    test_long_period();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
